// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: data memory with byte/half/word access, optional wait states and branch resolve.
// Optional macro MEM_STAGE_MISALIGN_EN: trap misaligned half/word accesses instead of aligning them.
module mem_stage_pipe #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] adder_result,
    input  logic [WIDTH-1:0] store_data,
    input  logic             zero,
    input  logic [4:0]       rd_in,
    input  logic [7:0]       ctrl,
    input  logic             flush,
    output logic             stall,
    output logic             pc_src,
    output logic [WIDTH-1:0] branch_target,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [WIDTH-1:0] wb_read_data,
    output logic [WIDTH-1:0] wb_alu_result,
    output logic [4:0]       wb_rd,
    output logic             wb_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_reg;
    logic [2:0]       cnt_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;
    logic [1:0]       ld_size_reg;
    logic [1:0]       ld_lane_reg;
    logic             ld_uns_reg;

    logic [AW-1:0]    idx;
    logic             is_byte, is_half, is_word;
    logic             mem_req, misalign;
    logic             start_wait, finish_wait, capture, live, we;
    logic [NB-1:0]    be;
    logic [WIDTH-1:0] wdata;

    assign pc_src        = in_valid & ctrl[1] & zero & ~flush;
    assign branch_target = adder_result;

    assign idx     = alu_result[AW+1:2];
    assign is_byte = (ctrl[6:5] == 2'b00);
    assign is_half = (ctrl[6:5] == 2'b01);
    assign is_word = ctrl[6];
    assign mem_req = in_valid & (ctrl[2] | ctrl[3]);

`ifdef MEM_STAGE_MISALIGN_EN
    assign misalign = mem_req & ((is_half & alu_result[0]) |
                                 (is_word & (alu_result[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Once in WAIT the access is committed: flush no longer matters.
    assign start_wait  = (MEM_LAT != 0) & (state_reg == IDLE) & mem_req & ~flush;
    assign finish_wait = (state_reg == WAIT) & (cnt_reg == 3'd1);
    assign stall       = ~rst & (start_wait | ((state_reg == WAIT) & (cnt_reg != 3'd1)));
    assign capture     = ((state_reg == IDLE) & ~start_wait) | finish_wait;
    assign live        = capture & in_valid & (~flush | (state_reg == WAIT));
    assign we          = ~rst & live & ctrl[3] & ~misalign;

    // Byte lanes: sub-word stores replicate their data across lanes and enable only the addressed ones.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            if (gi < 4) begin : g_low
                assign be[gi] = is_word |
                                (is_half & (alu_result[1] == ((gi / 2) != 0))) |
                                (is_byte & (alu_result[1:0] == 2'(gi)));
            end else begin : g_high
                assign be[gi] = is_word;
            end
            assign wdata[gi*8 +: 8] = is_word ? store_data[gi*8 +: 8] :
                                      is_half ? store_data[(gi%2)*8 +: 8] :
                                                store_data[7:0];
        end
    endgenerate

    // Read-first memory: the registered read always returns the pre-write word.
    always_ff @(posedge clk) begin
        rdata_reg <= mem[idx];
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_alu_result <= '0;
            wb_rd         <= 5'd0;
            wb_misalign   <= 1'b0;
            ld_size_reg   <= 2'b00;
            ld_lane_reg   <= 2'b00;
            ld_uns_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_wait) begin
                        state_reg <= WAIT;
                        cnt_reg   <= 3'(MEM_LAT);
                    end
                end
                WAIT: begin
                    if (cnt_reg == 3'd1) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 3'd0;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            wb_valid      <= live;
            wb_reg_write  <= live & ctrl[0] & ~misalign;
            wb_misalign   <= live & misalign;
            wb_mem_to_reg <= ctrl[4];
            wb_alu_result <= alu_result;
            wb_rd         <= rd_in;
            ld_size_reg   <= ctrl[6:5];
            ld_lane_reg   <= alu_result[1:0];
            ld_uns_reg    <= ctrl[7];
        end
    end

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_fmt;

    always_comb begin
        ld_byte = rdata_reg[{ld_lane_reg, 3'b000} +: 8];
        ld_half = rdata_reg[{ld_lane_reg[1], 4'b0000} +: 16];
        case (ld_size_reg)
            2'b00:   ld_fmt = {{(WIDTH-8){~ld_uns_reg & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{(WIDTH-16){~ld_uns_reg & ld_half[15]}}, ld_half};
            default: ld_fmt = rdata_reg;
        endcase
        wb_read_data = wb_valid ? ld_fmt : '0;
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: three instances (MEM_LAT 0/2/3) checked every cycle against a behavioural model.
module tb_mem_stage_pipe;
    localparam logic [7:0] ST_W  = 8'b0100_1000;
    localparam logic [7:0] ST_H  = 8'b0010_1000;
    localparam logic [7:0] ST_B  = 8'b0000_1000;
    localparam logic [7:0] LD_W  = 8'b0101_0101;
    localparam logic [7:0] LD_B  = 8'b0001_0101;
    localparam logic [7:0] LD_BU = 8'b1001_0101;
    localparam logic [7:0] BR    = 8'b0000_0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s [3], v_s [3], z_s [3], fl_s [3];
    logic [31:0] alu_s [3], add_s [3], sd_s [3];
    logic [4:0]  rd_s [3];
    logic [7:0]  c_s [3];
    logic        stall_s [3], pc_s [3], wv_s [3], wrw_s [3], wm2r_s [3], wmis_s [3];
    logic [31:0] bt_s [3], wrdata_s [3], walu_s [3];
    logic [4:0]  wrd_s [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
            mem_stage_pipe #(.WIDTH(32), .DEPTH(256), .MEM_LAT(LAT)) dut (
                .clk(clk), .rst(rst_s[gi]), .in_valid(v_s[gi]), .alu_result(alu_s[gi]),
                .adder_result(add_s[gi]), .store_data(sd_s[gi]), .zero(z_s[gi]),
                .rd_in(rd_s[gi]), .ctrl(c_s[gi]), .flush(fl_s[gi]), .stall(stall_s[gi]),
                .pc_src(pc_s[gi]), .branch_target(bt_s[gi]), .wb_valid(wv_s[gi]),
                .wb_reg_write(wrw_s[gi]), .wb_mem_to_reg(wm2r_s[gi]),
                .wb_read_data(wrdata_s[gi]), .wb_alu_result(walu_s[gi]), .wb_rd(wrd_s[gi]),
                .wb_misalign(wmis_s[gi])
            );
        end
    endgenerate

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, i, $time, act, req);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [3][256];
    int          age [3];
    bit          e_known [3], e_full [3], e_chkdata [3];
    logic        e_v [3], e_rw [3], e_mis [3], e_m2r [3];
    logic [31:0] e_alu [3], e_data [3];
    logic [4:0]  e_rd [3];

    logic [31:0] m_a, m_old, m_new, m_val;
    logic [1:0]  m_sz;
    bit          m_ismem, m_mis, m_stall, m_done;
    int          m_w, m_lane;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (e_known[i]) begin
                chk("wb_valid", i, 32'(wv_s[i]), 32'(e_v[i]));
                chk("wb_reg_write", i, 32'(wrw_s[i]), 32'(e_rw[i]));
                chk("wb_misalign", i, 32'(wmis_s[i]), 32'(e_mis[i]));
                if (e_full[i]) begin
                    chk("wb_mem_to_reg", i, 32'(wm2r_s[i]), 32'(e_m2r[i]));
                    chk("wb_alu_result", i, walu_s[i], e_alu[i]);
                    chk("wb_rd", i, 32'(wrd_s[i]), 32'(e_rd[i]));
                    if (e_chkdata[i]) chk("wb_read_data", i, wrdata_s[i], e_data[i]);
                end
            end
            m_ismem = v_s[i] && (c_s[i][2] || c_s[i][3]);
            m_stall = !rst_s[i] && lat_of(i) > 0 && m_ismem && (age[i] > 0 || !fl_s[i]) &&
                      age[i] < lat_of(i);
            chk("stall", i, 32'(stall_s[i]), 32'(m_stall));
            chk("pc_src", i, 32'(pc_s[i]), 32'(v_s[i] && c_s[i][1] && z_s[i] && !fl_s[i]));
            chk("branch_target", i, bt_s[i], add_s[i]);
            e_known[i] = 1'b1;
            if (rst_s[i]) begin
                age[i] = 0;
                e_v[i] = 0; e_rw[i] = 0; e_mis[i] = 0; e_m2r[i] = 0;
                e_alu[i] = 0; e_rd[i] = 0; e_data[i] = 0;
                e_full[i] = 1; e_chkdata[i] = 1;
            end else if (m_stall) begin
                age[i]++;
                e_v[i] = 0; e_rw[i] = 0; e_mis[i] = 0; e_full[i] = 0;
            end else begin
                m_done = v_s[i] && (!fl_s[i] || age[i] > 0);
                age[i] = 0;
                if (!m_done) begin
                    e_v[i] = 0; e_rw[i] = 0; e_mis[i] = 0; e_full[i] = 0;
                end else begin
                    m_a    = alu_s[i];
                    m_sz   = c_s[i][6:5];
                    m_w    = int'(m_a[9:2]);
                    m_lane = int'(m_a[1:0]);
`ifdef MEM_STAGE_MISALIGN_EN
                    m_mis = m_ismem && ((m_sz == 2'b01 && m_a[0]) || (m_sz[1] && m_a[1:0] != 2'b00));
`else
                    m_mis = 1'b0;
`endif
                    m_old = mdl_mem[i][m_w];
                    if (m_sz == 2'b00) begin
                        m_val = (m_old >> (8 * m_lane)) & 32'hFF;
                        if (!c_s[i][7] && m_val[7]) m_val = m_val | 32'hFFFF_FF00;
                    end else if (m_sz == 2'b01) begin
                        m_val = (m_old >> (16 * (m_lane / 2))) & 32'hFFFF;
                        if (!c_s[i][7] && m_val[15]) m_val = m_val | 32'hFFFF_0000;
                    end else begin
                        m_val = m_old;
                    end
                    if (c_s[i][3] && !m_mis) begin
                        m_new = m_old;
                        if (m_sz == 2'b00)
                            m_new[8*m_lane +: 8] = sd_s[i][7:0];
                        else if (m_sz == 2'b01)
                            m_new[16*(m_lane/2) +: 16] = sd_s[i][15:0];
                        else
                            m_new = sd_s[i];
                        mdl_mem[i][m_w] = m_new;
                    end
                    e_v[i] = 1; e_rw[i] = c_s[i][0] && !m_mis; e_mis[i] = m_mis;
                    e_m2r[i] = c_s[i][4]; e_alu[i] = m_a; e_rd[i] = rd_s[i];
                    e_data[i] = m_val; e_full[i] = 1;
                    e_chkdata[i] = c_s[i][2] && !m_mis;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input int i, input logic v, input logic [31:0] a, input logic [31:0] ad,
                          input logic [31:0] sd, input logic z, input logic [4:0] rd,
                          input logic [7:0] c, input logic fl);
        v_s[i] = v; alu_s[i] = a; add_s[i] = ad; sd_s[i] = sd;
        z_s[i] = z; rd_s[i] = rd; c_s[i] = c; fl_s[i] = fl;
    endtask

    // Hold the presented instruction until it is captured; returns the number of stalled cycles.
    task automatic run(input int i, input bit fl_rnd, output int stalls);
        logic s;
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            s = stall_s[i];
            @(posedge clk); #2;
            if (!s) return;
            stalls++;
            chk("stall_bubble", i, 32'(wv_s[i]), 32'd0);
            if (fl_rnd) fl_s[i] = 1'($urandom_range(0, 1));
        end
        checks++;
        errors++;
        $display("FAIL run_timeout inst=%0d t=%0t actual=stalled required=completion", i, $time);
    endtask

    task automatic op(input int i, input logic [31:0] a, input logic [31:0] sd,
                      input logic [7:0] c, output int stalls);
        set_in(i, 1'b1, a, 32'd0, sd, 1'b0, 5'd7, c, 1'b0);
        run(i, 1'b0, stalls);
        set_in(i, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b0);
    endtask

    function automatic logic [7:0] rnd_ctrl();
        logic [7:0] c;
        c = 8'd0;
        c[6:5] = 2'($urandom_range(0, 3));
        c[7]   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: c[0] = 1'b1;
            1: begin c[0] = 1'b1; c[2] = 1'b1; c[4] = 1'b1; end
            2: c[3] = 1'b1;
            default: c[1] = 1'b1;
        endcase
        return c;
    endfunction

    int st;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1;
            age[i] = 0;
            e_known[i] = 0;
            set_in(i, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_wb_valid", i, 32'(wv_s[i]), 32'd0);
            chk("rst_stall", i, 32'(stall_s[i]), 32'd0);
            chk("rst_read_data", i, wrdata_s[i], 32'd0);
            rst_s[i] = 1'b0;
        end

        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 256; w++)
                op(i, 32'(w * 4), $urandom, ST_W, st);

        // Instance 0, no wait states
        op(0, 32'h10, 32'hDEADBEEF, ST_W, st);
        chk("sw_stalls", 0, 32'(st), 32'd0);
        op(0, 32'h10, 32'd0, LD_W, st);
        chk("lw_stalls", 0, 32'(st), 32'd0);
        chk("lw_data", 0, wrdata_s[0], 32'hDEADBEEF);
        op(0, 32'h13, 32'h0000_0080, ST_B, st);
        op(0, 32'h13, 32'd0, LD_B, st);
        chk("lb_signed", 0, wrdata_s[0], 32'hFFFF_FF80);
        op(0, 32'h13, 32'd0, LD_BU, st);
        chk("lb_unsigned", 0, wrdata_s[0], 32'h0000_0080);
        op(0, 32'h10, 32'd0, LD_W, st);
        chk("lw_after_sb", 0, wrdata_s[0], 32'h80ADBEEF);

        set_in(0, 1'b1, 32'd0, 32'h40, 32'd0, 1'b1, 5'd0, BR, 1'b0);
        #1;
        chk("br_pc_src", 0, 32'(pc_s[0]), 32'd1);
        chk("br_target", 0, bt_s[0], 32'h40);
        run(0, 1'b0, st);
        set_in(0, 1'b1, 32'd0, 32'h40, 32'd0, 1'b1, 5'd3, 8'h01 | BR, 1'b1);
        #1;
        chk("br_flush_pc_src", 0, 32'(pc_s[0]), 32'd0);
        run(0, 1'b0, st);
        chk("flush_bubble", 0, 32'(wv_s[0]), 32'd0);
        chk("flush_bubble_rw", 0, 32'(wrw_s[0]), 32'd0);

        op(0, 32'h11, 32'h0000_1234, ST_H, st);
`ifdef MEM_STAGE_MISALIGN_EN
        chk("sh_misalign_flag", 0, 32'(wmis_s[0]), 32'd1);
        op(0, 32'h10, 32'd0, LD_W, st);
        chk("sh_misalign_nowrite", 0, wrdata_s[0], 32'h80ADBEEF);
`else
        chk("sh_misalign_flag", 0, 32'(wmis_s[0]), 32'd0);
        op(0, 32'h10, 32'd0, LD_W, st);
        chk("sh_aligned_write", 0, wrdata_s[0], 32'h80AD1234);
`endif

        // Instance 2, three wait states
        op(2, 32'h20, 32'h0BADF00D, ST_W, st);
        chk("lat3_sw_stalls", 2, 32'(st), 32'd3);
        op(2, 32'h20, 32'd0, LD_W, st);
        chk("lat3_lw_stalls", 2, 32'(st), 32'd3);
        chk("lat3_lw_valid", 2, 32'(wv_s[2]), 32'd1);
        chk("lat3_lw_data", 2, wrdata_s[2], 32'h0BADF00D);

        // Instance 1, reset during a pending store, then address aliasing
        op(1, 32'h10, 32'h11223344, ST_W, st);
        set_in(1, 1'b1, 32'h10, 32'd0, 32'hCAFEF00D, 1'b0, 5'd9, ST_W, 1'b0);
        @(negedge clk); #1;
        chk("lat2_stall_start", 1, 32'(stall_s[1]), 32'd1);
        @(posedge clk); #2;
        rst_s[1] = 1'b1;
        set_in(1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b0);
        @(posedge clk); #2;
        chk("rst_wait_valid", 1, 32'(wv_s[1]), 32'd0);
        chk("rst_wait_alu", 1, walu_s[1], 32'd0);
        chk("rst_wait_rd", 1, 32'(wrd_s[1]), 32'd0);
        chk("rst_wait_stall", 1, 32'(stall_s[1]), 32'd0);
        rst_s[1] = 1'b0;
        op(1, 32'h10, 32'd0, LD_W, st);
        chk("rst_aborted_store", 1, wrdata_s[1], 32'h11223344);
        op(1, 32'h410, 32'd0, LD_W, st);
        chk("alias_load", 1, wrdata_s[1], 32'h11223344);
        op(1, 32'h410, 32'h55667788, ST_W, st);
        op(1, 32'h10, 32'd0, LD_W, st);
        chk("alias_store", 1, wrdata_s[1], 32'h55667788);

        // Randomized traffic on every instance
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 250; n++) begin
                ra = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) ra = ra | (32'($urandom_range(1, 15)) << 10);
                set_in(i, 1'($urandom_range(0, 7) != 0), ra, $urandom, $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd_ctrl(),
                       1'($urandom_range(0, 7) == 0));
                run(i, 1'b1, st);
            end
            set_in(i, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
